fp_add: RTL and testbench

Registered fixed-point adder with per-operand signedness. It adds two fixed-point operands of independent integer/fraction widths and rounds the sum into a third parameterised format. It saturates on range violations and reports overflow and underflow. It sits in the arithmetic datapath wherever mixed-format Q-number sums are needed; outputs appear one clock after the inputs.

---
 rtl/fp_add.sv | 109 ++++++++++
 tb/tb_fp_add.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/fp_add.sv
// Registered mixed-format fixed-point adder.
// Aligns two Q-format operands, adds them exactly, rounds half up into the
// output format, saturates on range violations and flags overflow/underflow.
module fp_add #(
    parameter int i1 = 2,
    parameter int f1 = 14,
    parameter int i2 = 2,
    parameter int f2 = 14,
    parameter int i3 = 2,
    parameter int f3 = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [i1+f1-1:0]   a,
    input  logic               s1,
    input  logic [i2+f2-1:0]   b,
    input  logic               s2,
    output logic [i3+f3-1:0]   c,
    output logic               sign,
    output logic               overflow,
    output logic               underflow
);

    localparam int N1  = i1 + f1;
    localparam int N2  = i2 + f2;
    localparam int N3  = i3 + f3;
    // Common fraction width and integer width with two guard bits.
    localparam int F   = (f1 > f2) ? f1 : f2;
    localparam int I   = ((i1 > i2) ? i1 : i2) + 2;
    localparam int W   = I + F;
    // Output shift: left by UP when f3 >= F, round-and-right by DN otherwise.
    localparam int UP  = (f3 > F) ? (f3 - F) : 0;
    localparam int DN  = (F > f3) ? (F - f3) : 0;
    // Working width for the rounded value: wide enough for the shifted sum
    // and for comparing against both output limits without wrap-around.
    localparam int RW0 = W + UP + 1;
    localparam int RW  = (RW0 > N3 + 2) ? RW0 : N3 + 2;
    localparam int HSH = (DN > 0) ? (DN - 1) : 0;

    localparam logic signed [RW-1:0] HALF  = (DN > 0) ? (RW'(1) << HSH) : '0;
    localparam logic signed [RW-1:0] MAX_U = {{(RW-N3){1'b0}}, {N3{1'b1}}};
    localparam logic signed [RW-1:0] MAX_S = {{(RW-N3+1){1'b0}}, {(N3-1){1'b1}}};
    localparam logic signed [RW-1:0] MIN_S = {{(RW-N3+1){1'b1}}, {(N3-1){1'b0}}};

    logic signed [W-1:0]  a_x, b_x;
    logic signed [W-1:0]  a_al, b_al;
    logic signed [W-1:0]  sum;
    logic signed [RW-1:0] s_w;
    logic signed [RW-1:0] r;
    logic signed [RW-1:0] max_v, min_v;
    logic                 sgn;

    logic [N3-1:0] c_d, c_q;
    logic          sign_d, sign_q;
    logic          overflow_d, overflow_q;
    logic          underflow_d, underflow_q;

    // Align, add, round and saturate the current operands.
    always_comb begin
        a_x  = {{(W-N1){s1 & a[N1-1]}}, a};
        b_x  = {{(W-N2){s2 & b[N2-1]}}, b};
        a_al = a_x <<< (F - f1);
        b_al = b_x <<< (F - f2);
        sum  = a_al + b_al;
        s_w  = {{(RW-W){sum[W-1]}}, sum};
        if (DN > 0) begin
            r = (s_w + HALF) >>> DN;
        end else begin
            r = s_w <<< UP;
        end

        sgn   = s1 | s2;
        max_v = sgn ? MAX_S : MAX_U;
        min_v = sgn ? MIN_S : '0;

        c_d         = r[N3-1:0];
        sign_d      = sgn;
        overflow_d  = 1'b0;
        underflow_d = 1'b0;
        if (r > max_v) begin
            c_d        = max_v[N3-1:0];
            overflow_d = 1'b1;
        end else if (r < min_v) begin
            c_d         = min_v[N3-1:0];
            underflow_d = 1'b1;
        end
    end

    // Output register; reset discards any in-flight result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_q         <= '0;
            sign_q      <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            c_q         <= c_d;
            sign_q      <= sign_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign c         = c_q;
    assign sign      = sign_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_fp_add.sv
// Self-checking bench for fp_add with default formats: directed cases,
// asynchronous reset behaviour and randomized operands against a real-valued model.
module tb_fp_add;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] a = '0;
    logic        s1 = 1'b0;
    logic [15:0] b = '0;
    logic        s2 = 1'b0;
    logic [9:0]  c;
    logic        sign;
    logic        overflow;
    logic        underflow;

    int checks = 0;
    int errors = 0;

    fp_add dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .s1        (s1),
        .b         (b),
        .s2        (s2),
        .c         (c),
        .sign      (sign),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: real-valued sum, rounded half up to 2^-8, then clamped.
    function automatic real opval(input logic [15:0] v, input logic sg);
        real x;
        if (sg) x = $itor($signed(v));
        else    x = $itor(v);
        return x / 16384.0;
    endfunction

    task automatic model(input logic [15:0] ma, input logic ms1, input logic [15:0] mb,
                         input logic ms2, output logic [9:0] ec, output logic es,
                         output logic eov, output logic eun, output real esum);
        longint r, mx, mn;
        esum = opval(ma, ms1) + opval(mb, ms2);
        r    = longint'($floor(esum * 256.0 + 0.5));
        es   = ms1 | ms2;
        mx   = es ? 511 : 1023;
        mn   = es ? -512 : 0;
        eov  = 1'b0;
        eun  = 1'b0;
        if (r > mx) begin
            eov = 1'b1;
            r   = mx;
        end else if (r < mn) begin
            eun = 1'b1;
            r   = mn;
        end
        ec = r[9:0];
    endtask

    // Present one operand pair at the falling edge, sample the result one cycle later.
    task automatic apply(input logic [15:0] ta, input logic ts1, input logic [15:0] tb,
                         input logic ts2);
        a  = ta;
        s1 = ts1;
        b  = tb;
        s2 = ts2;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run(input string tag, input logic [15:0] ta, input logic ts1,
                       input logic [15:0] tb, input logic ts2);
        logic [9:0] ec;
        logic       es, eov, eun;
        real        esum, cv;
        model(ta, ts1, tb, ts2, ec, es, eov, eun, esum);
        apply(ta, ts1, tb, ts2);
        $display("%s a=%h s1=%0d b=%h s2=%0d -> c=%h sign=%0d ov=%0d un=%0d",
                 tag, ta, ts1, tb, ts2, c, sign, overflow, underflow);
        check({tag, ".c"}, c, ec);
        check({tag, ".sign"}, sign, es);
        check({tag, ".ov"}, overflow, eov);
        check({tag, ".un"}, underflow, eun);
        check({tag, ".excl"}, overflow & underflow, 1'b0);
        if (!overflow && !underflow) begin
            cv = sign ? $itor($signed(c)) / 256.0 : $itor(c) / 256.0;
            check({tag, ".tol"}, ((esum - cv) <= 0.001953125 && (cv - esum) <= 0.001953125), 1'b1);
        end
    endtask

    task automatic directed(input string tag, input logic [15:0] ta, input logic ts1,
                            input logic [15:0] tb, input logic ts2, input logic [9:0] xc,
                            input logic xs, input logic xov, input logic xun);
        apply(ta, ts1, tb, ts2);
        $display("%s c=%h sign=%0d ov=%0d un=%0d", tag, c, sign, overflow, underflow);
        check({tag, ".c"}, c, xc);
        check({tag, ".sign"}, sign, xs);
        check({tag, ".ov"}, overflow, xov);
        check({tag, ".un"}, underflow, xun);
    endtask

    initial begin
        logic [15:0] ra, rb;
        logic        rs1, rs2;

        // Reset state.
        #2;
        check("rst.c", c, 10'h000);
        check("rst.flags", {sign, overflow, underflow}, 3'b000);
        @(negedge clk);
        rst_n = 1'b1;

        directed("unsigned_add", 16'h4000, 1'b0, 16'h2000, 1'b0, 10'h180, 1'b0, 1'b0, 1'b0);
        directed("signed_add",   16'hC000, 1'b1, 16'h1000, 1'b1, 10'h340, 1'b1, 1'b0, 1'b0);
        directed("ovf_unsigned", 16'hC000, 1'b0, 16'h8000, 1'b0, 10'h3FF, 1'b0, 1'b1, 1'b0);
        directed("ovf_mixed",    16'hC000, 1'b0, 16'hE000, 1'b1, 10'h1FF, 1'b1, 1'b1, 1'b0);
        directed("underflow",    16'h8000, 1'b1, 16'hC000, 1'b1, 10'h200, 1'b1, 1'b0, 1'b1);
        directed("neg_unsigned", 16'h0000, 1'b0, 16'hF000, 1'b1, 10'h3C0, 1'b1, 1'b0, 1'b0);
        directed("round_half",   16'h0020, 1'b0, 16'h0000, 1'b0, 10'h001, 1'b0, 1'b0, 1'b0);
        directed("round_down",   16'h001F, 1'b0, 16'h0000, 1'b0, 10'h000, 1'b0, 1'b0, 1'b0);
        directed("round_ovf",    16'hFFE0, 1'b0, 16'h0000, 1'b0, 10'h3FF, 1'b0, 1'b1, 1'b0);
        directed("round_negh",   16'hFFE0, 1'b1, 16'h0000, 1'b1, 10'h000, 1'b1, 1'b0, 1'b0);

        // Asynchronous reset between edges, held across an edge, then released.
        apply(16'h4000, 1'b0, 16'h2000, 1'b0);
        check("pre_rst.c", c, 10'h180);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst.c", c, 10'h000);
        check("async_rst.flags", {sign, overflow, underflow}, 3'b000);
        a  = 16'hC000;
        s1 = 1'b1;
        @(posedge clk);
        #1;
        check("held_rst.c", c, 10'h000);
        check("held_rst.sign", sign, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        directed("post_rst", 16'hC000, 1'b1, 16'h1000, 1'b1, 10'h340, 1'b1, 1'b0, 1'b0);

        // Randomized operands.
        for (int n = 0; n < 100; n++) begin
            ra  = 16'($urandom);
            rb  = 16'($urandom);
            rs1 = 1'($urandom);
            rs2 = 1'($urandom);
            if (n % 4 == 0) ra = ra >> ($urandom_range(15, 4));
            if (n % 4 == 1) rb = rb >> ($urandom_range(15, 4));
            run($sformatf("rand%0d", n), ra, rs1, rb, rs2);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
